// File: rtl/fu_issue_arbiter_pkg.sv
// Shared types for the functional-unit issue arbiter: the reservation-station entry,
// the sequencer states and an index-width helper.
package fu_issue_arbiter_pkg;

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  rob_tag;
  } reservation_station_t;

  typedef enum logic [1:0] {
    FuIdle,
    FuStart,
    FuWait
  } fu_arb_state_t;

  // Keeps one index bit even for a single requester.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fu_issue_arbiter_if.sv
// Station/FU side signals of the issue arbiter; slave is the arbiter, master is
// the surrounding pipeline (stations, FU and CDB flush).
interface fu_issue_arbiter_if #(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned CNT_WIDTH = 32
);
  import fu_issue_arbiter_pkg::*;

  logic                                flush;
  logic                 [NUM_REQ-1:0]  req_valid;
  reservation_station_t [NUM_REQ-1:0]  req_entry;
  logic                 [NUM_REQ-1:0]  grant;
  logic                                fu_start;
  reservation_station_t                fu_entry;
  logic                                fu_done;
  logic                                fu_busy;
  logic                                timeout_err;
  logic                 [CNT_WIDTH-1:0] grant_cnt;
  logic                 [CNT_WIDTH-1:0] stall_cnt;

  modport slave (
    input  flush, req_valid, req_entry, fu_done,
    output grant, fu_start, fu_entry, fu_busy, timeout_err, grant_cnt, stall_cnt
  );

  modport master (
    output flush, req_valid, req_entry, fu_done,
    input  grant, fu_start, fu_entry, fu_busy, timeout_err, grant_cnt, stall_cnt
  );

endinterface

// File: rtl/fu_issue_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping
// modulo N. Also intended for CDB arbitration.
module fu_issue_arbiter_rr_arbiter
  import fu_issue_arbiter_pkg::*;
#(
  parameter int unsigned N    = 3,
  parameter int unsigned IdxW = idx_width(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [IdxW-1:0] i_ptr,
  output logic [N-1:0]    o_gnt,
  output logic [IdxW-1:0] o_idx,
  output logic            o_any
);

  always_comb begin
    int unsigned     cand;
    logic [IdxW-1:0] c_idx;
    cand  = 0;
    c_idx = '0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = 32'(i_ptr) + k;
      if (cand >= N) cand = cand - N;
      c_idx = IdxW'(cand);
      if (!o_any && i_req[c_idx]) begin
        o_any        = 1'b1;
        o_gnt[c_idx] = 1'b1;
        o_idx        = c_idx;
      end
    end
  end

endmodule

// File: rtl/fu_issue_arbiter.sv
// Issues reservation-station entries to one shared non-pipelined FU in round-robin
// order and sequences the FU start/done handshake, with timeout and perf counters.
module fu_issue_arbiter
  import fu_issue_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned CNT_WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  fu_issue_arbiter_if.slave bus
);

  localparam int unsigned IdxW = idx_width(NUM_REQ);
  localparam int unsigned TmrW = $clog2(TIMEOUT + 1);
  localparam logic [TmrW-1:0] TmrMax = TmrW'(TIMEOUT - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_REQ - 1);

  fu_arb_state_t        r_state;
  fu_arb_state_t        w_state_next;
  logic [IdxW-1:0]      r_rr_ptr;
  logic [TmrW-1:0]      r_timer;
  reservation_station_t r_fu_entry;
  logic                 r_timeout_err;
  logic [CNT_WIDTH-1:0] r_grant_cnt;
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  logic [NUM_REQ-1:0]   w_arb_gnt;
  logic [IdxW-1:0]      w_arb_idx;
  logic                 w_arb_any;
  logic                 w_grant_ok;
  logic                 w_do_grant;
  logic                 w_wait_tick;
  logic                 w_stall;
  logic [IdxW-1:0]      w_ptr_next;
  logic [TmrW-1:0]      w_timer_inc;

  fu_issue_arbiter_rr_arbiter #(
    .N    (NUM_REQ),
    .IdxW (IdxW)
  ) u_rr (
    .i_req (bus.req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx),
    .o_any (w_arb_any)
  );

  // A slot frees up when idle, or when the outstanding op completes this cycle.
  assign w_grant_ok  = rst_n && !bus.flush && ((r_state == FuIdle) || bus.fu_done);
  assign w_do_grant  = w_grant_ok && w_arb_any;
  assign w_wait_tick = (r_state == FuWait) && !bus.fu_done && !bus.flush;
  assign w_stall     = rst_n && !bus.flush && (|bus.req_valid) && !w_do_grant;
  assign w_ptr_next  = (w_arb_idx == IdxLast) ? '0 : w_arb_idx + 1'b1;
  assign w_timer_inc = r_timer + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= FuIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (bus.flush) begin
      w_state_next = FuIdle;
    end else begin
      case (r_state)
        FuIdle:          if (w_do_grant) w_state_next = FuStart;
        FuStart, FuWait: begin
          if (bus.fu_done) w_state_next = w_do_grant ? FuStart : FuIdle;
          else             w_state_next = FuWait;
        end
        default:         w_state_next = FuIdle;
      endcase
    end
  end

  always_comb begin
    bus.grant    = w_do_grant ? w_arb_gnt : '0;
    bus.fu_start = (r_state == FuStart);
    bus.fu_busy  = (r_state != FuIdle) && !((r_state == FuWait) && bus.fu_done);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr      <= '0;
      r_timer       <= '0;
      r_fu_entry    <= '0;
      r_timeout_err <= 1'b0;
      r_grant_cnt   <= '0;
      r_stall_cnt   <= '0;
    end else begin
      if (bus.flush) begin
        r_fu_entry.valid <= 1'b0;
      end else if (w_do_grant) begin
        r_fu_entry <= bus.req_entry[w_arb_idx];
        r_rr_ptr   <= w_ptr_next;
        r_timer    <= '0;
      end else if (w_wait_tick && (r_timer != TmrMax)) begin
        r_timer <= w_timer_inc;
      end
      if (w_wait_tick && (w_timer_inc == TmrMax)) r_timeout_err <= 1'b1;
      if (w_do_grant && (r_grant_cnt != '1)) r_grant_cnt <= r_grant_cnt + 1'b1;
      if (w_stall && (r_stall_cnt != '1))    r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.fu_entry    = r_fu_entry;
  assign bus.timeout_err = r_timeout_err;
  assign bus.grant_cnt   = r_grant_cnt;
  assign bus.stall_cnt   = r_stall_cnt;

endmodule
